// File: rtl/freq_ratio_calc.sv
// freq_ratio_calc: f = Nx * F_BASE_HZ / Nb via 32-cycle shift-add multiply then 64-cycle restoring divide.
// Define FREQ_RATIO_ROUND_EN for round-half-up; otherwise the quotient truncates.
module freq_ratio_calc #(
  parameter int unsigned F_BASE_HZ = 100_000_000,
  parameter int          CNT_W     = 32
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [CNT_W-1:0] fx_cnt,
  input  logic [CNT_W-1:0] fbase_cnt,
  input  logic             cnt_valid,
  output logic [CNT_W-1:0] freq_hz,
  output logic             freq_valid,
  output logic             div_err,
  output logic             busy
);
  localparam int AW = 2 * CNT_W;
  localparam int CW = $clog2(AW);
  localparam logic [AW-1:0] FB = AW'(F_BASE_HZ);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] nx_q, nx_d, nb_q, nb_d, rem_q, rem_d, freq_hz_q, freq_hz_d;
  logic [AW-1:0]    mc_q, mc_d, acc_q, acc_d, mul_acc, rnd;
  logic [CNT_W:0]   r_sh;
  logic             zero_q, zero_d, freq_valid_q, freq_valid_d, div_err_q, div_err_d;
  logic             ge, sat, last_mul;
`ifdef FREQ_RATIO_ROUND_EN
  assign rnd = AW'(nb_q >> 1);
`else
  assign rnd = '0;
`endif
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  assign last_mul = cnt_q == CW'(CNT_W - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cnt_valid) state_d = MUL;
      MUL:  if (last_mul) state_d = DIV;
      DIV:  if (cnt_q == CW'(AW - 1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // freq_valid extends busy across the result cycle, after the FSM is already back in IDLE
  always_comb busy = (state_q != IDLE) || freq_valid_q;
  assign freq_hz    = freq_hz_q;
  assign freq_valid = freq_valid_q;
  assign div_err    = div_err_q;
  // acc holds the product during MUL and shifts into the quotient during DIV
  always_comb begin
    cnt_d        = cnt_q;
    nx_d         = nx_q;
    nb_d         = nb_q;
    mc_d         = mc_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    zero_d       = zero_q;
    freq_hz_d    = freq_hz_q;
    div_err_d    = div_err_q;
    freq_valid_d = 1'b0;
    r_sh         = {rem_q, acc_q[AW-1]};
    ge           = r_sh >= {1'b0, nb_q};
    sat          = zero_q || (|acc_q[AW-1:CNT_W]);
    mul_acc      = acc_q + (nx_q[0] ? mc_q : '0);
    case (state_q)
      IDLE: if (cnt_valid) begin
        cnt_d  = '0;
        nx_d   = fx_cnt;
        nb_d   = fbase_cnt;
        mc_d   = FB;
        acc_d  = '0;
        rem_d  = '0;
        zero_d = fbase_cnt == '0;
      end
      MUL: begin
        nx_d  = nx_q >> 1;
        mc_d  = mc_q << 1;
        cnt_d = last_mul ? '0 : cnt_q + 1'b1;
        acc_d = last_mul ? mul_acc + rnd : mul_acc;
      end
      DIV: begin
        rem_d = ge ? CNT_W'(r_sh - {1'b0, nb_q}) : r_sh[CNT_W-1:0];
        acc_d = {acc_q[AW-2:0], ge};
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        freq_hz_d    = sat ? '1 : acc_q[CNT_W-1:0];
        div_err_d    = sat;
        freq_valid_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      cnt_q        <= '0;
      nx_q         <= '0;
      nb_q         <= '0;
      mc_q         <= '0;
      acc_q        <= '0;
      rem_q        <= '0;
      zero_q       <= 1'b0;
      freq_hz_q    <= '0;
      div_err_q    <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      nx_q         <= nx_d;
      nb_q         <= nb_d;
      mc_q         <= mc_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      zero_q       <= zero_d;
      freq_hz_q    <= freq_hz_d;
      div_err_q    <= div_err_d;
      freq_valid_q <= freq_valid_d;
    end
endmodule

// File: tb/tb_freq_ratio_calc.sv
// tb_freq_ratio_calc: vector table plus scoreboard queue, with hand sequences for drop, back-to-back and reset cases.
module tb_freq_ratio_calc;
  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fx_cnt = '0;
  logic [31:0] fbase_cnt = '0;
  logic        cnt_valid = 1'b0;
  logic [31:0] freq_hz;
  logic        freq_valid, div_err, busy;
  typedef struct {logic [31:0] hz; logic err;} exp_t;
  typedef struct {logic [31:0] nx; logic [31:0] nb; logic [31:0] hz; logic err;} vec_t;
  exp_t sb[$];
  vec_t vt[12];
  int tests = 0;
  int fails = 0;
  int fv_count = 0;
  freq_ratio_calc dut (
    .sysclk(sysclk), .reset(reset), .fx_cnt(fx_cnt), .fbase_cnt(fbase_cnt),
    .cnt_valid(cnt_valid), .freq_hz(freq_hz), .freq_valid(freq_valid),
    .div_err(div_err), .busy(busy)
  );
  always #5 sysclk = ~sysclk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  always @(negedge sysclk) if (freq_valid) begin
    exp_t e;
    fv_count++;
    if (sb.size() == 0) chk("unexpected_freq_valid", 1, 0);
    else begin
      e = sb.pop_front();
      chk("freq_hz", freq_hz, e.hz);
      chk("div_err", div_err, e.err);
    end
  end
  task automatic drive(input logic [31:0] nx, input logic [31:0] nb);
    fx_cnt = nx;
    fbase_cnt = nb;
    cnt_valid = 1'b1;
  endtask
  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask
  // Returns the edge index (capture edge = 0) at which freq_valid is first seen.
  task automatic wait_fv(output int lat);
    lat = 0;
    while (!freq_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask
  task automatic run_pair(input logic [31:0] nx, input logic [31:0] nb, input logic [31:0] hz, input logic err);
    int lat;
    @(negedge sysclk);
    drive(nx, nb);
    sb.push_back('{hz, err});
    tick();
    cnt_valid = 1'b0;
    chk("busy_rise", busy, 1);
    wait_fv(lat);
    chk("latency", lat, 97);
    chk("busy_at_valid", busy, 1);
    tick();
    chk("freq_valid_one_cycle", freq_valid, 0);
    chk("busy_fall", busy, 0);
  endtask
  initial begin
    int lat, busy_cnt, fv0;
    vt[0]  = '{32'd1000, 32'd100_000_000, 32'd1000, 1'b0};
`ifdef FREQ_RATIO_ROUND_EN
    vt[1]  = '{32'd2, 32'd3, 32'd66_666_667, 1'b0};
`else
    vt[1]  = '{32'd2, 32'd3, 32'd66_666_666, 1'b0};
`endif
    vt[2]  = '{32'd100, 32'd1, 32'hFFFF_FFFF, 1'b1};
    vt[3]  = '{32'd3, 32'd2, 32'd150_000_000, 1'b0};
    vt[4]  = '{32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1};
    vt[5]  = '{32'd7, 32'd7, 32'd100_000_000, 1'b0};
    vt[6]  = '{32'd42, 32'd1, 32'd4_200_000_000, 1'b0};
    vt[7]  = '{32'd43, 32'd1, 32'hFFFF_FFFF, 1'b1};
    vt[8]  = '{32'd0, 32'd5, 32'd0, 1'b0};
    vt[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100_000_000, 1'b0};
    vt[10] = '{32'd1, 32'd3, 32'd33_333_333, 1'b0};
    vt[11] = '{32'd12345, 32'd99_999_999, 32'd12345, 1'b0};
    #12;
    chk("reset_freq_hz", freq_hz, 0);
    chk("reset_freq_valid", freq_valid, 0);
    chk("reset_div_err", div_err, 0);
    chk("reset_busy", busy, 0);
    @(negedge sysclk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) run_pair(vt[i].nx, vt[i].nb, vt[i].hz, vt[i].err);
    // second cnt_valid mid-flight must be dropped
    fv0 = fv_count;
    @(negedge sysclk);
    drive(32'd10, 32'd10);
    sb.push_back('{32'd100_000_000, 1'b0});
    tick();
    cnt_valid = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 200 && busy; n++) begin
      busy_cnt++;
      if (n == 40) drive(32'd20, 32'd10);
      if (n == 41) cnt_valid = 1'b0;
      tick();
    end
    chk("drop_busy_cycles", busy_cnt, 98);
    repeat (110) tick();
    chk("drop_single_valid", fv_count - fv0, 1);
    // cnt_valid on the DONE edge is ignored; on the next edge it is accepted
    fv0 = fv_count;
    @(negedge sysclk);
    drive(32'd1000, 32'd100_000_000);
    sb.push_back('{32'd1000, 1'b0});
    tick();
    cnt_valid = 1'b0;
    for (int n = 0; n < 96; n++) tick();
    drive(32'd9, 32'd1);
    tick();
    chk("done_edge_valid", freq_valid, 1);
    drive(32'd3, 32'd2);
    sb.push_back('{32'd150_000_000, 1'b0});
    tick();
    cnt_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_fv(lat);
    chk("b2b_latency", lat, 97);
    repeat (110) tick();
    chk("b2b_valid_count", fv_count - fv0, 2);
    // reset mid-computation aborts without a result
    fv0 = fv_count;
    @(negedge sysclk);
    drive(32'd10, 32'd10);
    tick();
    cnt_valid = 1'b0;
    repeat (49) tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_freq_hz", freq_hz, 0);
    chk("abort_div_err", div_err, 0);
    chk("abort_freq_valid", freq_valid, 0);
    @(negedge sysclk);
    reset = 1'b1;
    repeat (120) tick();
    chk("abort_no_valid", fv_count - fv0, 0);
    run_pair(32'd7, 32'd7, 32'd100_000_000, 1'b0);
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
